// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell shared by the serial arithmetic paths.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one operand bit pair per clock, LSB first,
// through a single full adder with a carry flip-flop closing the loop.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_reg;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sr_reg;
    logic [WIDTH-1:0]   b_sr_reg;
    logic [WIDTH-1:0]   psum_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic [WIDTH-1:0]   b_load;
    logic               fa_s;
    logic               fa_cout;
    logic               accept;
    logic               last_bit;

    // Subtraction is a + ~b + 1: invert B on load, the +1 comes from the carry seed.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
            assign b_load[gi] = b[gi] ^ sub;
        end
    endgenerate

    assign accept   = start && (state_reg != RUN);
    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

    fulladder u_fa (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_bit ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sr_reg  <= '0;
            b_sr_reg  <= '0;
            psum_reg  <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_sr_reg  <= a;
            b_sr_reg  <= b_load;
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_sr_reg  <= a_sr_reg >> 1;
            b_sr_reg  <= b_sr_reg >> 1;
            psum_reg  <= {fa_s, psum_reg[WIDTH-1:1]};
            carry_reg <= fa_cout;
            cnt_reg   <= cnt_reg + 1'b1;
            if (last_bit) begin
                // carry_reg still holds the carry into the MSB on this edge.
                sum_reg  <= {fa_s, psum_reg[WIDTH-1:1]};
                cout_reg <= fa_cout;
                ovf_reg  <= carry_reg ^ fa_cout;
            end
        end
    end

    assign sum      = sum_reg;
    assign cout     = cout_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl at WIDTH=8.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Pulse start for one accepting edge, then count edges until done (bounded).
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         input logic is, output int lat);
        @(negedge clk);
        a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        $display("reset: busy=%b done=%b sum=%h cout=%b ovf=%b", busy, done, sum, cout, overflow);
    endtask

    task automatic test_add();
        int lat;
        do_op(8'h3C, 8'h2A, 1'b1, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL add_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h67) begin errors++; $display("FAIL add_sum got=%h exp=67", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got=%b exp=0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL add_ovf got=%b exp=0", overflow); end
        $display("add 3C+2A+1: lat=%0d sum=%h cout=%b ovf=%b", lat, sum, cout, overflow);
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got=%b exp=0", done); end
        checks++; if (sum !== 8'h67) begin errors++; $display("FAIL add_sum_hold got=%h exp=67", sum); end
    endtask

    task automatic test_overflow();
        int lat;
        do_op(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        checks++; if (sum !== 8'h80) begin errors++; $display("FAIL ovf1_sum got=%h exp=80", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL ovf1_cout got=%b exp=0", cout); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf1_ovf got=%b exp=1", overflow); end
        $display("add 7F+01: lat=%0d sum=%h cout=%b ovf=%b", lat, sum, cout, overflow);
        do_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL ovf2_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL ovf2_cout got=%b exp=1", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf2_ovf got=%b exp=0", overflow); end
        $display("add FF+01: lat=%0d sum=%h cout=%b ovf=%b", lat, sum, cout, overflow);
    endtask

    task automatic test_subtract();
        int lat;
        do_op(8'h05, 8'h07, 1'b0, 1'b1, lat);
        checks++; if (sum !== 8'hFE) begin errors++; $display("FAIL sub1_sum got=%h exp=FE", sum); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL sub1_cout got=%b exp=0", cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub1_ovf got=%b exp=0", overflow); end
        $display("sub 05-07: lat=%0d sum=%h cout=%b ovf=%b", lat, sum, cout, overflow);
        // cin=1 must be ignored in subtract mode
        do_op(8'h80, 8'h01, 1'b1, 1'b1, lat);
        checks++; if (sum !== 8'h7F) begin errors++; $display("FAIL sub2_sum got=%h exp=7F", sum); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub2_cout got=%b exp=1", cout); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sub2_ovf got=%b exp=1", overflow); end
        $display("sub 80-01: lat=%0d sum=%h cout=%b ovf=%b", lat, sum, cout, overflow);
    endtask

    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        a = 8'h3C; b = 8'h2A; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got=%b exp=1", busy); end
        a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 8) begin errors++; $display("FAIL ign_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h67) begin errors++; $display("FAIL ign_sum got=%h exp=67", sum); end
        $display("start mid-run ignored: lat=%0d sum=%h", lat, sum);
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        int gap;
        int first;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; start = 1'b1;
        first = 0;
        while (!done && first < 40) begin @(posedge clk); #1; first++; end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b exp=1", done); end
        for (int i = 0; i < 2; i++) begin
            gap = 0;
            @(posedge clk); #1; gap++;
            while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
            checks++; if (gap !== 9) begin errors++; $display("FAIL b2b_gap%0d got=%0d exp=9", i, gap); end
            checks++; if (sum !== 8'h30) begin errors++; $display("FAIL b2b_sum%0d got=%h exp=30", i, sum); end
            $display("back-to-back %0d: gap=%0d sum=%h", i, gap, sum);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        @(negedge clk);
        a = 8'h55; b = 8'h11; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rst_sum got=%h exp=00", sum); end
        checks++; if (cout !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rst_flags got=%b%b exp=00", cout, overflow);
        end
        seen = 0;
        repeat (12) begin @(posedge clk); #1; if (done) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", seen); end
        $display("reset mid-run: busy=%b sum=%h done_pulses=%0d", busy, sum, seen);
        do_op(8'h12, 8'h34, 1'b0, 1'b0, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rst_after_latency got=%0d exp=8", lat); end
        checks++; if (sum !== 8'h46) begin errors++; $display("FAIL rst_after_sum got=%h exp=46", sum); end
        $display("after reset 12+34: lat=%0d sum=%h", lat, sum);
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_subtract();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
